// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one grant per cycle onto a single memory port, 1-cycle read responses.
// Contention is fixed-priority (requester 0 wins) unless DMEM_ARB_RR_EN is defined, which selects round-robin.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } resp_state_e;

    logic [1:0]            valid;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    logic [1:0]            grant;
    logic [1:0]            read_accept;
    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata [2];

    logic                  last_grant_q;
    logic                  last_grant_d;

    assign valid    = {req1_valid, req0_valid};
    assign we       = {req1_we, req0_we};
    assign addr[0]  = req0_addr;
    assign addr[1]  = req1_addr;
    assign wdata[0] = req0_wdata;
    assign wdata[1] = req1_wdata;

    // Grant is purely combinational so ready tracks valid within the same cycle.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                grant = last_grant_q ? 2'b01 : 2'b10;
`else
                grant = 2'b01;
`endif
            end else begin
                grant = valid;
            end
        end
    end

    assign read_accept = grant & ~we;

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (grant[0]) begin
            mem_addr       = addr[0];
            mem_write_data = wdata[0];
            mem_write      = we[0];
            mem_read       = ~we[0];
        end else if (grant[1]) begin
            mem_addr       = addr[1];
            mem_write_data = wdata[1];
            mem_write      = we[1];
            mem_read       = ~we[1];
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    // Reset value 1 makes requester 0 the winner of the first round-robin contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            resp_state_e           state_q;
            resp_state_e           state_d;
            logic [DATA_WIDTH-1:0] rdata_q;
            logic [DATA_WIDTH-1:0] rdata_d;

            always_comb begin
                state_d = state_q;
                rdata_d = rdata_q;
                case (state_q)
                    S_IDLE: begin
                        if (read_accept[gi]) begin
                            state_d = S_RESP;
                        end
                    end
                    S_RESP: begin
                        state_d = read_accept[gi] ? S_RESP : S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
                // Memory read data is combinational, so capture it at the accepting edge.
                if (read_accept[gi]) begin
                    rdata_d = mem_read_data;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= S_IDLE;
                    rdata_q <= '0;
                end else begin
                    state_q <= state_d;
                    rdata_q <= rdata_d;
                end
            end

            assign rvalid[gi] = (state_q == S_RESP);
            assign rdata[gi]  = rdata_q;
        end
    endgenerate

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign req0_rvalid = rvalid[0];
    assign req1_rvalid = rvalid[1];
    assign req0_rdata  = rdata[0];
    assign req1_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [9:0]  req0_addr;
    logic [63:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [9:0]  req1_addr;
    logic [63:0] req1_wdata, req1_rdata;
    logic [9:0]  mem_addr;
    logic [63:0] mem_write_data, mem_read_data;
    logic        mem_write, mem_read;

    // Environment memory: combinational read, written on the clock edge.
    logic [63:0] mem_arr [1024];
    logic        init_we;
    logic [9:0]  init_addr;
    logic [63:0] init_data;

    // Reference model state
    logic [63:0] ref_mem [1024];
    logic        exp_rvalid [2];
    logic [63:0] exp_rdata  [2];
    int          lg;
    logic        seen_r0, seen_r1;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    dmem_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem_arr[mem_addr];

    always @(posedge clk) begin
        if (init_we) begin
            mem_arr[init_addr] <= init_data;
        end else if (mem_write) begin
            mem_arr[mem_addr] <= mem_write_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (reset) return -1;
        if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
            return (lg == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        exp_rvalid[0] = 1'b0;
        exp_rvalid[1] = 1'b0;
        exp_rdata[0]  = '0;
        exp_rdata[1]  = '0;
        lg            = 1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [9:0] a0, input logic [63:0] d0,
                         input logic v1, input logic w1, input logic [9:0] a1, input logic [63:0] d1);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    // One clock cycle: check all outputs mid-cycle, advance the model, return just after the edge.
    task automatic step();
        int          g;
        logic [9:0]  a;
        logic [63:0] wd;
        logic        w;
        @(negedge clk);
        g  = model_grant();
        a  = (g == 0) ? req0_addr  : (g == 1) ? req1_addr  : '0;
        wd = (g == 0) ? req0_wdata : (g == 1) ? req1_wdata : '0;
        w  = (g == 0) ? req0_we    : (g == 1) ? req1_we    : 1'b0;
        check_eq("req0_ready", 64'(req0_ready), 64'(g == 0));
        check_eq("req1_ready", 64'(req1_ready), 64'(g == 1));
        check_eq("mem_write", 64'(mem_write), 64'(g >= 0 && w));
        check_eq("mem_read", 64'(mem_read), 64'(g >= 0 && !w));
        check_eq("mem_addr", 64'(mem_addr), 64'(a));
        check_eq("mem_write_data", mem_write_data, wd);
        check_eq("req0_rvalid", 64'(req0_rvalid), 64'(exp_rvalid[0]));
        check_eq("req1_rvalid", 64'(req1_rvalid), 64'(exp_rvalid[1]));
        check_eq("req0_rdata", req0_rdata, exp_rdata[0]);
        check_eq("req1_rdata", req1_rdata, exp_rdata[1]);
        seen_r0 = req0_ready;
        seen_r1 = req1_ready;
        $display("cyc %0d: v=%b%b we=%b%b grant=%0d addr=%0d rvalid=%b%b",
                 cyc, req1_valid, req0_valid, req1_we, req0_we, g, a, req1_rvalid, req0_rvalid);
        exp_rvalid[0] = 1'b0;
        exp_rvalid[1] = 1'b0;
        if (g >= 0) begin
            lg = g;
            if (w) begin
                ref_mem[a] = wd;
            end else begin
                exp_rvalid[g] = 1'b1;
                exp_rdata[g]  = ref_mem[a];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready0"}, 64'(req0_ready), 64'd0);
        check_eq({tag, "_ready1"}, 64'(req1_ready), 64'd0);
        check_eq({tag, "_rvalid0"}, 64'(req0_rvalid), 64'd0);
        check_eq({tag, "_rvalid1"}, 64'(req1_rvalid), 64'd0);
        check_eq({tag, "_rdata0"}, req0_rdata, 64'd0);
        check_eq({tag, "_rdata1"}, req1_rdata, 64'd0);
        check_eq({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        check_eq({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_eq({tag, "_mem_wdata"}, mem_write_data, 64'd0);
    endtask

    logic exp_r0_pat [4];
    logic exp_r1_pat [4];

    initial begin
        reset   = 1'b1;
        init_we = 1'b0;
        init_addr = '0;
        init_data = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Preload the first 32 words while in reset; random traffic stays inside them.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            init_we   = 1'b1;
            init_addr = 10'(i);
            init_data = (i == 7) ? 64'd70 : (i == 8) ? 64'd80 : (i == 9) ? 64'd90 : {$urandom, $urandom};
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_we = 1'b0;

        // Outputs held at zero during reset even with requests pending.
        drive(1, 0, 10'd1, 64'h11, 1, 0, 10'd2, 64'h22);
        #1;
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contention for 4 cycles; first grant comes right after reset release.
`ifdef DMEM_ARB_RR_EN
        exp_r0_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_r1_pat = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_r0_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_r1_pat = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, (i < 2) ? 10'd1 : 10'd2, 0, 1, 0, (i < 2) ? 10'd1 : 10'd2, 0);
            step();
            check_eq("contend_ready0", 64'(seen_r0), 64'(exp_r0_pat[i]));
            check_eq("contend_ready1", 64'(seen_r1), 64'(exp_r1_pat[i]));
        end

        // Idle: no grant, no memory strobes, no response afterwards.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_eq("idle_mem_read", 64'(mem_read), 64'd0);
        check_eq("idle_mem_write", 64'(mem_write), 64'd0);
        check_eq("idle_rvalid0", 64'(req0_rvalid), 64'd0);
        check_eq("idle_rvalid1", 64'(req1_rvalid), 64'd0);

        // Write then read back through requester 0.
        drive(1, 1, 10'd5, 64'hAA, 0, 0, 0, 0);
        #1;
        check_eq("wr_mem_write", 64'(mem_write), 64'd1);
        check_eq("wr_mem_addr", 64'(mem_addr), 64'd5);
        step();
        drive(1, 0, 10'd5, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rd_rvalid", 64'(req0_rvalid), 64'd1);
        check_eq("rd_rdata", req0_rdata, 64'hAA);
        step();

        // Three back-to-back reads on requester 1.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 10'(7 + i), 0);
            step();
            check_eq("b2b_rvalid1", 64'(req1_rvalid), 64'd1);
            check_eq("b2b_rdata1", req1_rdata, 64'(70 + 10 * i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("b2b_done_rvalid1", 64'(req1_rvalid), 64'd0);

        // Reset lands in the response cycle and must kill the pulse immediately.
        drive(1, 0, 10'd3, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 10'd4, 0, 1, 1, 10'd6, 64'h55);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                  {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                  {$urandom, $urandom});
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
